// File: rtl/opb_pkg.sv
// opb_pkg: shared OPB address map, master state encoding and bus width
package opb_pkg;
    localparam int OPB_DW = 32;
    localparam logic [OPB_DW-1:0] ADDR_VERSION = 32'd0;
    localparam logic [OPB_DW-1:0] ADDR_ID      = 32'd1;
    localparam logic [OPB_DW-1:0] ADDR_DATE    = 32'd2;
    localparam logic [OPB_DW-1:0] ADDR_SP1     = 32'd3;
    localparam logic [OPB_DW-1:0] ADDR_SP2     = 32'd4;
    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RSP} state_t;
endpackage

// File: rtl/opb_master.sv
// opb_master: single-outstanding OPB bus initiator with command/response handshakes
module opb_master
    import opb_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter logic [OPB_DW-1:0] ADDR_LIMIT = 32'h0000_000F
) (
    input  logic              OPB_CLK,
    input  logic              OPB_RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [OPB_DW-1:0] cmd_addr,
    input  logic [OPB_DW-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OPB_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [OPB_DW-1:0] OPB_ADDR,
    output logic [OPB_DW-1:0] OPB_WDATA,
    output logic              OPB_RE,
    output logic              OPB_WE,
    input  logic [OPB_DW-1:0] OPB_RDATA,
    output logic              busy,
    output logic [15:0]       txn_count
);
    localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

    state_t state, state_nxt;
    logic [1:0] wait_cnt;
    logic accept, bad_addr;

    assign cmd_ready = (state == IDLE) & ~OPB_RST;
    assign accept    = cmd_valid & cmd_ready;
    assign bad_addr  = cmd_addr > ADDR_LIMIT;
    assign OPB_WE    = state == WR;
    assign OPB_RE    = state == RD;
    assign rsp_valid = state == RSP;
    assign busy      = state != IDLE;

    always_ff @(posedge OPB_CLK or posedge OPB_RST)
        if (OPB_RST) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = bad_addr ? RSP : (cmd_write ? WR : RD);
            WR:      state_nxt = RSP;
            RD:      state_nxt = RD_WAIT;
            RD_WAIT: if (wait_cnt == 2'd0) state_nxt = RSP;
            RSP:     if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Rejected commands skip the bus and never count as transactions
    always_ff @(posedge OPB_CLK or posedge OPB_RST)
        if (OPB_RST) begin
            OPB_ADDR  <= '0;
            OPB_WDATA <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= 2'd0;
            txn_count <= 16'd0;
        end else begin
            if (accept && bad_addr) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
            if (accept && !bad_addr) OPB_ADDR <= cmd_addr;
            if (accept && !bad_addr && cmd_write) OPB_WDATA <= cmd_wdata;
            if (state == WR) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
            if (state == RD) wait_cnt <= WAIT_INIT;
            if (state == RD_WAIT && wait_cnt == 2'd0) begin
                rsp_rdata <= OPB_RDATA;
                rsp_err   <= 1'b0;
            end
            if (state == RD_WAIT && wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
            if (state == RSP && rsp_ready && !rsp_err) txn_count <= txn_count + 16'd1;
        end
endmodule
